// File: rtl/wb_master_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Grant encodings are one-hot so the FSM state doubles as the gnt_o vector.
package wb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_e;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteDisable = 1'b0;

endpackage

// File: rtl/wb_master_arbiter_mux.sv
// Combinational request mux (master -> slave) and response demux (slave -> master),
// steered by the one-hot grant; with no grant everything is driven to idle values.
module wb_master_mux
    import wb_master_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic [1:0]      gnt,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_data_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_data_o,
    output logic            m0_ack_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_data_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_data_o,
    output logic            m1_ack_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_data_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_stb_o,
    output logic            s_cyc_o,
    input  logic [DW-1:0]   s_data_i,
    input  logic            s_ack_i
);

    always_comb begin
        s_addr_o  = AW'(ZeroWord);
        s_data_o  = DW'(ZeroWord);
        s_sel_o   = '0;
        s_we_o    = WriteDisable;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        m0_data_o = DW'(ZeroWord);
        m0_ack_o  = 1'b0;
        m1_data_o = DW'(ZeroWord);
        m1_ack_o  = 1'b0;
        case (gnt)
            ARB_GNT0: begin
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
                s_sel_o   = m0_sel_i;
                s_we_o    = m0_we_i;
                s_stb_o   = m0_stb_i;
                s_cyc_o   = m0_cyc_i;
                m0_data_o = s_data_i;
                m0_ack_o  = s_ack_i;
            end
            ARB_GNT1: begin
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
                s_sel_o   = m1_sel_i;
                s_we_o    = m1_we_i;
                s_stb_o   = m1_stb_i;
                s_cyc_o   = m1_cyc_i;
                m1_data_o = s_data_i;
                m1_ack_o  = s_ack_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: m0 (data side) and m1 (instruction side) share one slave.
// Define WB_ARB_RR_EN to break simultaneous requests round-robin instead of m0-first.
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_data_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_data_o,
    output logic            m0_ack_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_data_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_data_o,
    output logic            m1_ack_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_data_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_stb_o,
    output logic            s_cyc_o,
    input  logic [DW-1:0]   s_data_i,
    input  logic            s_ack_i,
    output logic [1:0]      gnt_o
);

    arb_state_e state_q, state_d;

`ifdef WB_ARB_RR_EN
    // 1 = m1 held the most recent grant; reset value lets m0 win the first tie.
    logic last_gnt_q, last_gnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
`ifdef WB_ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
`ifdef WB_ARB_RR_EN
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d    = last_gnt_q ? ARB_GNT0 : ARB_GNT1;
                    last_gnt_d = ~last_gnt_q;
                end else if (m0_cyc_i) begin
                    state_d    = ARB_GNT0;
                    last_gnt_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d    = ARB_GNT1;
                    last_gnt_d = 1'b1;
                end
`else
                if (m0_cyc_i) begin
                    state_d = ARB_GNT0;
                end else if (m1_cyc_i) begin
                    state_d = ARB_GNT1;
                end
`endif
            end
            ARB_GNT0: if (!m0_cyc_i) state_d = ARB_IDLE;
            ARB_GNT1: if (!m1_cyc_i) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    assign gnt_o = state_q;

    wb_master_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .gnt       (gnt_o),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_addr_i (m0_addr_i),
        .m0_data_i (m0_data_i),
        .m0_sel_i  (m0_sel_i),
        .m0_data_o (m0_data_o),
        .m0_ack_o  (m0_ack_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_addr_i (m1_addr_i),
        .m1_data_i (m1_data_i),
        .m1_sel_i  (m1_sel_i),
        .m1_data_o (m1_data_o),
        .m1_ack_o  (m1_ack_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_stb_o   (s_stb_o),
        .s_cyc_o   (s_cyc_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i)
    );

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: per-cycle vector table with expected grant,
// routed outputs derived from that grant, compared through an expectation queue.
module tb_wb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_data_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_data_o;
    logic        m0_ack_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_data_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_data_o;
    logic        m1_ack_o;
    logic [31:0] s_addr_o, s_data_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [31:0] s_data_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;

    always #5 clk = ~clk;

    wb_master_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    typedef struct packed {
        logic        m0c, m0s, m0w;
        logic [31:0] m0a, m0d;
        logic [3:0]  m0sel;
        logic        m1c, m1s, m1w;
        logic [31:0] m1a, m1d;
        logic [3:0]  m1sel;
        logic        sack;
        logic [31:0] sdat;
    } in_t;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        s_cyc, s_stb, s_we;
        logic [31:0] s_addr, s_data;
        logic [3:0]  s_sel;
        logic        m0_ack;
        logic [31:0] m0_data;
        logic        m1_ack;
        logic [31:0] m1_data;
    } out_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [1:0] gnt;
    } vec_t;

    vec_t  tbl[$];
    out_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Expected bus outputs once the grant for this cycle is known.
    function automatic out_t route(in_t v, logic [1:0] g);
        out_t o;
        o = '0;
        o.gnt = g;
        if (g == 2'b01) begin
            o.s_cyc = v.m0c; o.s_stb = v.m0s; o.s_we = v.m0w;
            o.s_addr = v.m0a; o.s_data = v.m0d; o.s_sel = v.m0sel;
            o.m0_ack = v.sack; o.m0_data = v.sdat;
        end else if (g == 2'b10) begin
            o.s_cyc = v.m1c; o.s_stb = v.m1s; o.s_we = v.m1w;
            o.s_addr = v.m1a; o.s_data = v.m1d; o.s_sel = v.m1sel;
            o.m1_ack = v.sack; o.m1_data = v.sdat;
        end
        return o;
    endfunction

    function automatic in_t mk(bit m0c, bit m0s, bit m0w, logic [31:0] m0a, logic [31:0] m0d,
                               bit m1c, bit m1s, logic [31:0] m1a, logic [31:0] m1d,
                               bit sack, logic [31:0] sdat);
        in_t v;
        v.m0c = m0c; v.m0s = m0s; v.m0w = m0w; v.m0a = m0a; v.m0d = m0d; v.m0sel = 4'hF;
        v.m1c = m1c; v.m1s = m1s; v.m1w = 1'b0; v.m1a = m1a; v.m1d = m1d; v.m1sel = 4'h3;
        v.sack = sack; v.sdat = sdat;
        return v;
    endfunction

    task automatic add(string nm, in_t v, logic [1:0] g);
        vec_t t;
        t.name = nm; t.in = v; t.gnt = g;
        tbl.push_back(t);
    endtask

    task automatic drive(in_t v);
        m0_cyc_i = v.m0c; m0_stb_i = v.m0s; m0_we_i = v.m0w;
        m0_addr_i = v.m0a; m0_data_i = v.m0d; m0_sel_i = v.m0sel;
        m1_cyc_i = v.m1c; m1_stb_i = v.m1s; m1_we_i = v.m1w;
        m1_addr_i = v.m1a; m1_data_i = v.m1d; m1_sel_i = v.m1sel;
        s_ack_i = v.sack; s_data_i = v.sdat;
    endtask

    function automatic out_t sample();
        out_t a;
        a.gnt = gnt_o; a.s_cyc = s_cyc_o; a.s_stb = s_stb_o; a.s_we = s_we_o;
        a.s_addr = s_addr_o; a.s_data = s_data_o; a.s_sel = s_sel_o;
        a.m0_ack = m0_ack_o; a.m0_data = m0_data_o;
        a.m1_ack = m1_ack_o; a.m1_data = m1_data_o;
        return a;
    endfunction

    task automatic expect_out(string nm, out_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_pop();
        out_t  e, a;
        string nm;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: nothing expected when a DUT sample was taken");
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = sample();
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got gnt=%b cyc=%b stb=%b we=%b addr=%h wdat=%h sel=%h a0=%b d0=%h a1=%b d1=%h / want gnt=%b cyc=%b stb=%b we=%b addr=%h wdat=%h sel=%h a0=%b d0=%h a1=%b d1=%h",
                         nm, a.gnt, a.s_cyc, a.s_stb, a.s_we, a.s_addr, a.s_data, a.s_sel,
                         a.m0_ack, a.m0_data, a.m1_ack, a.m1_data,
                         e.gnt, e.s_cyc, e.s_stb, e.s_we, e.s_addr, e.s_data, e.s_sel,
                         e.m0_ack, e.m0_data, e.m1_ack, e.m1_data);
            end
        end
    endtask

    initial begin
        in_t        z, v;
        logic [1:0] win;

        z = mk(0,0,0,0,0, 0,0,0,0, 0,0);

        add("idle",        z, 2'b00);
        add("spurious_ack", mk(0,0,0,0,0, 0,0,0,0, 1,32'hAAAA_5555), 2'b00);
        add("rd_req",      mk(1,1,0,32'h100,0, 0,0,0,0, 0,0), 2'b00);
        add("rd_gnt",      mk(1,1,0,32'h100,0, 0,0,0,0, 0,0), 2'b01);
        add("rd_wait",     mk(1,1,0,32'h100,0, 0,0,0,0, 0,0), 2'b01);
        add("rd_ack",      mk(1,1,0,32'h100,0, 0,0,0,0, 1,32'hDEAD_BEEF), 2'b01);
        add("rd_drop",     z, 2'b01);
        add("rd_release",  z, 2'b00);
        add("wr_req",      mk(1,1,1,32'h200,32'h1234_5678, 0,0,0,0, 0,0), 2'b00);
        add("wr_m1_wait",  mk(1,1,1,32'h200,32'h1234_5678, 1,1,32'h300,32'h55, 0,0), 2'b01);
        add("wr_ack",      mk(1,1,1,32'h200,32'h1234_5678, 1,1,32'h300,32'h55, 1,0), 2'b01);
        add("wr_drop",     mk(0,0,1,32'h200,32'h1234_5678, 1,1,32'h300,32'h55, 0,0), 2'b01);
        add("m1_gap",      mk(0,0,1,32'h200,32'h1234_5678, 1,1,32'h300,32'h55, 0,0), 2'b00);
        add("m1_gnt",      mk(0,0,1,32'h200,32'h1234_5678, 1,1,32'h300,32'h55, 0,0), 2'b10);
        add("m1_wait",     mk(0,0,1,32'h200,32'h1234_5678, 1,1,32'h300,32'h55, 0,0), 2'b10);
        add("m1_ack_drop", mk(0,0,0,0,0, 0,0,0,0, 1,32'hCAFE_F00D), 2'b10);
        add("post_m1",     z, 2'b00);
        for (int r = 0; r < 4; r++) begin
`ifdef WB_ARB_RR_EN
            win = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
            win = 2'b01;
`endif
            v = mk(1,1,0,32'h1000 + r,0, 1,1,32'h2000 + r,0, 0,0);
            add($sformatf("tie%0d_req", r), v, 2'b00);
            v.sack = 1'b1; v.sdat = 32'h0BAD_0000 + r;
            add($sformatf("tie%0d_ack", r), v, win);
            add($sformatf("tie%0d_drop", r), z, win);
        end
        add("m1_after_req", mk(0,0,0,0,0, 1,1,32'h3000,0, 0,0), 2'b00);
        add("m1_after_ack", mk(0,0,0,0,0, 1,1,32'h3000,0, 1,32'h7777_0001), 2'b10);
        add("m1_after_drop", z, 2'b10);
        add("final_idle",   z, 2'b00);

        drive(z);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset_state", route(z, 2'b00));
        check_pop();
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i].in);
            expect_out(tbl[i].name, route(tbl[i].in, tbl[i].gnt));
            @(negedge clk);
            check_pop();
        end

        // Reset in the middle of an m1 grant with the slave ack still outstanding.
        v = mk(0,0,0,0,0, 1,1,32'h400,32'h99, 0,0);
        @(posedge clk); #1 drive(v);
        expect_out("rst_m1_req", route(v, 2'b00));
        @(negedge clk); check_pop();
        @(posedge clk); #1;
        expect_out("rst_m1_gnt", route(v, 2'b10));
        @(negedge clk); check_pop();
        @(posedge clk); #2 rst = 1'b1;
        #1;
        expect_out("rst_async_drop", route(v, 2'b00));
        check_pop();
        @(posedge clk); #1 rst = 1'b0;
        v = mk(1,1,0,32'h500,0, 0,0,0,0, 0,0);
        drive(v);
        expect_out("post_rst_req", route(v, 2'b00));
        @(negedge clk); check_pop();
        @(posedge clk); #1;
        expect_out("post_rst_gnt", route(v, 2'b01));
        @(negedge clk); check_pop();
        @(posedge clk); #1;
        v.sack = 1'b1; v.sdat = 32'h0000_5A5A;
        drive(v);
        expect_out("post_rst_ack", route(v, 2'b01));
        @(negedge clk); check_pop();
        @(posedge clk); #1 drive(z);

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d leftover expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
